// File: rtl/tdm2p.sv
// TDM receiver: recovers fs-aligned 8 x 32-bit frames from an oversampled serial stream.
// Optional build macro TDM2P_SYNC_EN adds 2-flop synchronizers on sclk, fs and tdmin.
module tdm2p #(
  parameter int MISS_LIMIT = 1
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         enable,
  input  logic         sclk,
  input  logic         fs,
  input  logic         tdmin,
  output logic         valid,
  output logic [255:0] pdata,
  output logic         locked,
  output logic         bitSlipIncr,
  output logic         lostSyncIncr
);

  // state  | meaning
  // HUNT   | waiting for an fs-marked bit to start a frame
  // LOCKED | aligned; shifting bits, flywheeling over missing fs

  typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

  localparam logic [3:0] MISS_LAST = 4'(MISS_LIMIT - 1);

  logic sclk_s, fs_s, tdm_s;
  logic sclk_d;
  logic rise;

`ifdef TDM2P_SYNC_EN
  logic [1:0] sclk_q, fs_q, tdm_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sclk_q <= '0;
      fs_q   <= '0;
      tdm_q  <= '0;
    end else begin
      sclk_q <= {sclk_q[0], sclk};
      fs_q   <= {fs_q[0], fs};
      tdm_q  <= {tdm_q[0], tdmin};
    end
  end

  assign sclk_s = sclk_q[1];
  assign fs_s   = fs_q[1];
  assign tdm_s  = tdm_q[1];
`else
  assign sclk_s = sclk;
  assign fs_s   = fs;
  assign tdm_s  = tdmin;
`endif

  assign rise = sclk_s & ~sclk_d;

  state_t       state;
  logic [7:0]   cnt;
  logic [3:0]   miss;
  // Bit 255 never lands here: it is merged straight into pdata on the last event.
  logic [254:0] sr;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sclk_d       <= 1'b0;
      state        <= HUNT;
      cnt          <= '0;
      miss         <= '0;
      sr           <= '0;
      pdata        <= '0;
      valid        <= 1'b0;
      locked       <= 1'b0;
      bitSlipIncr  <= 1'b0;
      lostSyncIncr <= 1'b0;
    end else begin
      sclk_d       <= sclk_s;
      valid        <= 1'b0;
      bitSlipIncr  <= 1'b0;
      lostSyncIncr <= 1'b0;
      if (!enable) begin
        state  <= HUNT;
        locked <= 1'b0;
        cnt    <= '0;
        miss   <= '0;
        sr     <= '0;
      end else if (rise) begin
        case (state)
          HUNT: begin
            if (fs_s) begin
              sr[0]  <= tdm_s;
              cnt    <= 8'd1;
              miss   <= '0;
              state  <= LOCKED;
              locked <= 1'b1;
            end
          end
          LOCKED: begin
            if (fs_s) begin
              // fs mid-frame: drop the partial frame and realign on this bit
              if (cnt != 8'd0) bitSlipIncr <= 1'b1;
              sr[0] <= tdm_s;
              cnt   <= 8'd1;
              miss  <= '0;
            end else if (cnt != 8'd0) begin
              if (cnt == 8'd255) begin
                pdata <= {tdm_s, sr};
                valid <= 1'b1;
              end else begin
                sr[cnt] <= tdm_s;
              end
              cnt <= cnt + 8'd1;
            end else if (miss < MISS_LAST) begin
              miss  <= miss + 4'd1;
              sr[0] <= tdm_s;
              cnt   <= 8'd1;
            end else begin
              lostSyncIncr <= 1'b1;
              state        <= HUNT;
              locked       <= 1'b0;
            end
          end
          default: begin
            state  <= HUNT;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tdm2p.sv
// Bench for tdm2p: two instances (MISS_LIMIT 1 and 2) fed the same stream, checked
// against a frame-level reference model at directed checkpoints.
`timescale 1ns/1ps
module tb_tdm2p;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic enable = 1'b0;
  logic sclk = 1'b0;
  logic fs = 1'b0;
  logic tdmin = 1'b0;

  logic         v1, v2, lk1, lk2, sl1, sl2, ls1, ls2;
  logic [255:0] pd1, pd2;

  always #5 clk = ~clk;

  tdm2p #(.MISS_LIMIT(1)) u_dut1 (
    .clk(clk), .rstn(rstn), .enable(enable), .sclk(sclk), .fs(fs), .tdmin(tdmin),
    .valid(v1), .pdata(pd1), .locked(lk1), .bitSlipIncr(sl1), .lostSyncIncr(ls1)
  );

  tdm2p #(.MISS_LIMIT(2)) u_dut2 (
    .clk(clk), .rstn(rstn), .enable(enable), .sclk(sclk), .fs(fs), .tdmin(tdmin),
    .valid(v2), .pdata(pd2), .locked(lk2), .bitSlipIncr(sl2), .lostSyncIncr(ls2)
  );

  int checks = 0;
  int errors = 0;

  // reference model: one partial-frame accumulator per instance
  int           lim[2] = '{1, 2};
  bit           mlk[2];
  logic [255:0] macc[2];
  logic [255:0] mlast[2];
  int           mn[2];
  int           mmiss[2];
  int           e_valid[2], e_slip[2], e_lost[2];
  int           o_valid[2], o_slip[2], o_lost[2];
  logic [255:0] expq0[$], expq1[$], obsq0[$], obsq1[$];

  bit fast = 1'b0;
  logic [31:0] lfsr = 32'hACE1_2468;

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_vec(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void model_clear();
    for (int m = 0; m < 2; m++) begin
      mlk[m]   = 1'b0;
      mn[m]    = 0;
      mmiss[m] = 0;
    end
  endfunction

  function automatic void model_step(input logic f, input logic d);
    for (int m = 0; m < 2; m++) begin
      if (!mlk[m]) begin
        if (f) begin
          mlk[m] = 1'b1; macc[m] = '0; macc[m][0] = d; mn[m] = 1; mmiss[m] = 0;
        end
      end else if (f) begin
        if (mn[m] != 0) e_slip[m]++;
        macc[m] = '0; macc[m][0] = d; mn[m] = 1; mmiss[m] = 0;
      end else if (mn[m] == 0) begin
        if (mmiss[m] + 1 < lim[m]) begin
          mmiss[m]++; macc[m] = '0; macc[m][0] = d; mn[m] = 1;
        end else begin
          e_lost[m]++; mlk[m] = 1'b0;
        end
      end else begin
        macc[m][mn[m]] = d;
        mn[m]++;
        if (mn[m] == 256) begin
          e_valid[m]++;
          mlast[m] = macc[m];
          if (m == 0) expq0.push_back(macc[m]);
          else expq1.push_back(macc[m]);
          mn[m] = 0;
        end
      end
    end
  endfunction

  always @(negedge clk) begin
    if (v1) begin o_valid[0]++; obsq0.push_back(pd1); end
    if (v2) begin o_valid[1]++; obsq1.push_back(pd2); end
    if (sl1) o_slip[0]++;
    if (sl2) o_slip[1]++;
    if (ls1) o_lost[0]++;
    if (ls2) o_lost[1]++;
    if (sl1 | ls1 | sl2 | ls2) begin
      checks++;
      assert (!(sl1 && ls1) && !(sl2 && ls2)) else begin
        errors++;
        $error("FAIL pulse_overlap observed slip1=%b lost1=%b slip2=%b lost2=%b expected no overlap",
               sl1, ls1, sl2, ls2);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // called at a negedge; leaves sclk high at a negedge
  task automatic send_bit(input logic f, input logic d);
    int lo, hi;
    lo = fast ? 2 : int'($urandom_range(2, 3));
    hi = fast ? 2 : int'($urandom_range(2, 3));
    #($urandom_range(0, 3));
    sclk = 1'b0; fs = f; tdmin = d;
    repeat (lo) @(negedge clk);
    #($urandom_range(0, 3));
    sclk = 1'b1;
    model_step(f, d);
    repeat (hi) @(negedge clk);
  endtask

  task automatic send_frame(input logic [255:0] fr, input bit with_fs, input int first, input int last);
    for (int i = first; i <= last; i++) send_bit(with_fs && (i == 0), fr[i]);
  endtask

  function automatic logic [255:0] rand_frame();
    logic [255:0] fr;
    for (int k = 0; k < 8; k++) fr[32*k +: 32] = $urandom;
    return fr;
  endfunction

  function automatic logic [255:0] lfsr_frame();
    logic [255:0] fr;
    for (int i = 0; i < 256; i++) begin
      lfsr = {lfsr[30:0], lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0]};
      fr[i] = lfsr[0];
    end
    return fr;
  endfunction

  task automatic checkpoint(input string tag);
    idle(6);
    chk_int({tag, " valid_cnt1"}, o_valid[0], e_valid[0]);
    chk_int({tag, " valid_cnt2"}, o_valid[1], e_valid[1]);
    chk_int({tag, " slip_cnt1"}, o_slip[0], e_slip[0]);
    chk_int({tag, " slip_cnt2"}, o_slip[1], e_slip[1]);
    chk_int({tag, " lost_cnt1"}, o_lost[0], e_lost[0]);
    chk_int({tag, " lost_cnt2"}, o_lost[1], e_lost[1]);
    chk_int({tag, " locked1"}, int'(lk1), int'(mlk[0]));
    chk_int({tag, " locked2"}, int'(lk2), int'(mlk[1]));
    while (expq0.size() > 0 && obsq0.size() > 0)
      chk_vec({tag, " pdata1"}, obsq0.pop_front(), expq0.pop_front());
    while (expq1.size() > 0 && obsq1.size() > 0)
      chk_vec({tag, " pdata2"}, obsq1.pop_front(), expq1.pop_front());
    expq0.delete(); obsq0.delete(); expq1.delete(); obsq1.delete();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk_int({tag, " valid1"}, int'(v1), 0);
    chk_int({tag, " valid2"}, int'(v2), 0);
    chk_vec({tag, " pdata1"}, pd1, '0);
    chk_vec({tag, " pdata2"}, pd2, '0);
    chk_int({tag, " locked1"}, int'(lk1), 0);
    chk_int({tag, " locked2"}, int'(lk2), 0);
    chk_int({tag, " pulses"}, int'({sl1, sl2, ls1, ls2}), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] clean, ra, rb, rc, rd, re;
    model_clear();
    for (int k = 0; k < 8; k++) clean[32*k +: 32] = 32'h1111_1111 * k;

    // reset state
    idle(3);
    chk_reset_outputs("reset");
    rstn = 1'b1;
    enable = 1'b1;
    idle(2);

    // clean stream, lock on the first fs
    send_frame(clean, 1'b1, 0, 0);
    idle(4);
    chk_int("first_fs locked1", int'(lk1), 1);
    chk_int("first_fs locked2", int'(lk2), 1);
    send_frame(clean, 1'b1, 1, 255);
    send_frame(clean, 1'b1, 0, 255);
    send_frame(clean, 1'b1, 0, 255);
    checkpoint("clean");
    chk_vec("clean top_word", {224'h0, pd1[255:224]}, {224'h0, 32'h7777_7777});
    chk_vec("clean ch0_word", {224'h0, pd1[31:0]}, '0);

    // bit slip at bit 100
    ra = rand_frame(); rb = rand_frame(); rc = rand_frame();
    send_frame(ra, 1'b1, 0, 255);
    send_frame(rb, 1'b1, 0, 99);
    send_frame(rc, 1'b1, 0, 255);
    checkpoint("slip");

    // fs missing on two frames
    ra = rand_frame(); rb = rand_frame(); rc = rand_frame(); rd = rand_frame(); re = rand_frame();
    send_frame(ra, 1'b1, 0, 255);
    send_frame(rb, 1'b0, 0, 255);
    send_frame(rc, 1'b0, 0, 0);
    checkpoint("lost_mid");
    send_frame(rc, 1'b0, 1, 255);
    send_frame(rd, 1'b1, 0, 255);
    send_frame(re, 1'b1, 0, 255);
    checkpoint("lost");

    // enable drop at bit 130
    ra = rand_frame(); rb = rand_frame(); rc = rand_frame();
    send_frame(ra, 1'b1, 0, 255);
    send_frame(rb, 1'b1, 0, 130);
    idle(4);
    enable = 1'b0;
    model_clear();
    idle(2);
    chk_int("en_drop locked1", int'(lk1), 0);
    chk_int("en_drop locked2", int'(lk2), 0);
    chk_vec("en_drop pdata_hold1", pd1, mlast[0]);
    chk_vec("en_drop pdata_hold2", pd2, mlast[1]);
    idle(8);
    enable = 1'b1;
    send_frame(rb, 1'b0, 131, 255);
    send_frame(rc, 1'b1, 0, 255);
    checkpoint("enable");

    // async reset at bit 200
    ra = rand_frame(); rb = rand_frame(); rc = rand_frame();
    send_frame(ra, 1'b1, 0, 255);
    send_frame(rb, 1'b1, 0, 200);
    idle(4);
    checkpoint("pre_reset");
    sclk = 1'b0;
    #2;
    rstn = 1'b0;
    #1;
    chk_reset_outputs("async_reset");
    model_clear();
    idle(3);
    rstn = 1'b1;
    idle(2);
    send_frame(rb, 1'b0, 201, 255);
    send_frame(rc, 1'b1, 0, 255);
    checkpoint("post_reset");

    // 4x oversampling, random phase, LFSR data
    fast = 1'b1;
    for (int f = 0; f < 30; f++) send_frame(lfsr_frame(), 1'b1, 0, 255);
    checkpoint("oversample");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
